line_refill: RTL and testbench
==============================

# line_refill

Cache-side receiver for read-miss line fills. On a miss it issues one line-aligned read request to the system bus, collects the four 32-bit words returned in ascending order, and forwards the critical word to the CPU as soon as it arrives (early restart). When the line is complete it writes the 128-bit line with its tag and index into the cache arrays. It sits between the cache controller and the system bus and consumes the same aligned read address the cache sends on a miss.

## Interface
- ADDRWIDTH, 32, address width
- DATAWIDTH, 32, system bus word width
- WORDS, 4, words per line (16-byte line)
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous assertion, active low
- miss_req  input  1  read-miss start, sampled in IDLE only
- miss_addr  input  ADDRWIDTH  CPU byte address of the missing access
- sys_req  output  1  read request to the system bus
- sys_addr  output  ADDRWIDTH  {miss_addr[31:4], 4'b0}
- sys_rw  output  1  fixed at `PREAD while sys_req=1, else 0
- sys_gnt  input  1  request accepted, single-cycle pulse
- sys_valid  input  1  sys_data holds the next line word
- sys_data  input  DATAWIDTH  returned word
- cpu_word  output  DATAWIDTH  critical word
- cpu_word_valid  output  1  cpu_word is valid this cycle
- line_we  output  1  line write strobe, one cycle
- line_data  output  WORDS*DATAWIDTH  assembled line, word0 in [31:0]
- line_tag  output  22  miss_addr[31:10]
- line_index  output  6  miss_addr[9:4]
- busy  output  1  high in every state except IDLE
- fill_done  output  1  pulse coincident with line_we

## Operation
- States: IDLE, REQ, FILL, WRITE. Encoded as a 2-bit enum.
- IDLE:
  - On miss_req, latch miss_addr and go to REQ.
  - Clear the word counter and the line buffer.
- REQ:
  - sys_req=1; sys_addr and sys_rw are driven.
  - On sys_gnt go to FILL with cnt=0.
  - sys_valid is ignored in this state, including in the same cycle as sys_gnt.
- FILL:
  - Each cycle with sys_valid=1, store sys_data into buffer[cnt] and increment cnt (2-bit).
  - Gaps (sys_valid=0) hold all state.
  - When sys_valid=1 and cnt==3, go to WRITE.
- WRITE:
  - line_we=1 and fill_done=1 for exactly one cycle.
  - line_data, line_tag and line_index are stable in this cycle.
  - Next state is IDLE.
- Critical word:
  - crit = latched addr[3:2].
  - In FILL, when sys_valid=1 and cnt==crit: cpu_word=sys_data and cpu_word_valid=1 in the same cycle (combinational).
  - Asserted exactly once per fill.
- miss_req outside IDLE is ignored; the cache controller must hold or retry it.
- sys_gnt or sys_valid in IDLE or WRITE is ignored.
- Reset values (async, rst_n=0):
  - State IDLE, cnt=0, buffer and latched address all zero.
  - Outputs: sys_req, sys_rw, cpu_word_valid, line_we, fill_done and busy are 0; all data and address outputs are 0.
- Reset during FILL abandons the fill: no line_we is issued, and the bus side must drop its remaining beats.

## Timing
- miss_req in cycle 0 puts the block in REQ in cycle 1; sys_req rises in cycle 1.
- sys_gnt in cycle k: sys_req is high up to and including cycle k and low from k+1. FILL starts at k+1.
- With back-to-back beats at k+1..k+4, line_we is asserted in cycle k+5. A new miss_req is accepted from k+6.
- Minimum miss-to-line_we latency: 6 cycles (with sys_gnt in cycle 1).
- State-derived outputs (sys_req, busy, line_we, fill_done) are decoded from registered state only. cpu_word and cpu_word_valid are the only combinational paths from inputs.

## Structure
- cache_pkg:
  - TAG_W=22, INDEX_W=6, OFFSET_W=4, WORD_SEL_W=2.
  - refill_state_t enum.
  - Line type as logic [WORDS-1:0][DATAWIDTH-1:0].
- PREAD/PWRITE come from macro.sv.
- Sub-module line_buffer:
  - Indexed 4×32 register with write-enable, write index and clear.
  - Parallel 128-bit read-out.
  - Async active-low reset.
- The FSM, counter and critical-word compare stay in line_refill.

## Test plan
- Basic fill:
  - Stimulus: miss_addr=0x0000_1238, sys_gnt in cycle 2, words 0xA0..0xA3 back-to-back.
  - Required: sys_addr=0x0000_1230 and sys_rw=`PREAD. cpu_word=0xA2 with cpu_word_valid when the third beat arrives. line_data={A3,A2,A1,A0}, line_index=0x23, line_tag=0x4. One line_we pulse.
- Gapped beats with critical word 0:
  - Stimulus: addr 0xFFFF_FFF0, sys_valid 1,0,1,0,0,1,1.
  - Required: cpu_word_valid only on the first beat; line_we the cycle after the 4th beat; line_tag=0x3FFFFF, line_index=0x3F.
- Spurious inputs:
  - Stimulus: sys_valid together with sys_gnt in REQ; sys_valid in IDLE; miss_req while busy.
  - Required: none of these beats are captured; the second miss is ignored; exactly 4 words stored.
- Reset mid-fill:
  - Stimulus: rst_n low after 2 beats.
  - Required: outputs go to zero asynchronously; no line_we; a following miss fills cleanly with a fresh buffer.
- Back-to-back misses:
  - Stimulus: miss_req held high through a fill (addr 0x100, then 0x210).
  - Required: the second fill starts the cycle after WRITE with a new sys_addr; two line_we pulses; busy low for exactly one cycle between the fills.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry, refill state encoding and line type
package cache_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int TAG_W      = 22;
   localparam int INDEX_W    = 6;
   localparam int OFFSET_W   = 4;
   localparam int WORD_SEL_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_FILL  = 2'd2,
      ST_WRITE = 2'd3
   } refill_state_t;

   typedef logic [LINE_WORDS-1:0][DATA_W-1:0] line_t;

endpackage

// File: rtl/line_refill_if.sv
// rtl/line_refill_if.sv - system bus read channel between the refill engine and the bus
interface line_refill_if #(
   parameter int ADDRWIDTH = 32,
   parameter int DATAWIDTH = 32
);

   logic                 sys_req;
   logic [ADDRWIDTH-1:0] sys_addr;
   logic                 sys_rw;
   logic                 sys_gnt;
   logic                 sys_valid;
   logic [DATAWIDTH-1:0] sys_data;

   // refill engine side: issues the request and receives the beats
   modport master (
      output sys_req, sys_addr, sys_rw,
      input  sys_gnt, sys_valid, sys_data
   );

   // bus side: grants the request and returns the beats
   modport slave (
      input  sys_req, sys_addr, sys_rw,
      output sys_gnt, sys_valid, sys_data
   );

endinterface

// File: rtl/line_refill_line_buffer.sv
// rtl/line_refill_line_buffer.sv - indexed word register holding one cache line
module line_buffer
   import cache_pkg::*;
#(
   parameter int DATAWIDTH = DATA_W,
   parameter int WORDS     = LINE_WORDS,
   parameter int IDX_W     = WORD_SEL_W
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            clr,
   input  logic                            we,
   input  logic [IDX_W-1:0]                widx,
   input  logic [DATAWIDTH-1:0]            wdata,
   output logic [WORDS-1:0][DATAWIDTH-1:0] line
);

   logic [WORDS-1:0][DATAWIDTH-1:0] mem_q;
   logic [WORDS-1:0][DATAWIDTH-1:0] mem_d;

   // clear wins over a write so a new miss always starts from an empty line
   always_comb begin
      mem_d = mem_q;
      if (clr) begin
         mem_d = '0;
      end else if (we) begin
         mem_d[widx] = wdata;
      end
   end

   // word storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign line = mem_q;

endmodule

// File: rtl/macro.sv
// rtl/macro.sv - system bus read/write direction codes
`ifndef MACRO_SV
`define MACRO_SV

`define PREAD  1'b1
`define PWRITE 1'b0

`endif

// File: rtl/line_refill.sv
// rtl/line_refill.sv - read-miss line fill engine with critical-word early restart
`include "macro.sv"

module line_refill
   import cache_pkg::*;
#(
   parameter int ADDRWIDTH = ADDR_W,
   parameter int DATAWIDTH = DATA_W,
   parameter int WORDS     = LINE_WORDS
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            miss_req,
   input  logic [ADDRWIDTH-1:0]            miss_addr,
   line_refill_if.master                   sys,
   output logic [DATAWIDTH-1:0]            cpu_word,
   output logic                            cpu_word_valid,
   output logic                            line_we,
   output logic [WORDS-1:0][DATAWIDTH-1:0] line_data,
   output logic [TAG_W-1:0]                line_tag,
   output logic [INDEX_W-1:0]              line_index,
   output logic                            busy,
   output logic                            fill_done
);

   refill_state_t         state_q, state_d;
   logic [WORD_SEL_W-1:0] cnt_q, cnt_d;
   logic [ADDRWIDTH-1:0]  addr_q, addr_d;
   logic                  sys_req_q, sys_req_d;
   logic                  sys_rw_q, sys_rw_d;
   logic                  busy_q, busy_d;
   logic                  line_we_q, line_we_d;

   logic                  buf_clr;
   logic                  buf_we;
   logic [WORD_SEL_W-1:0] crit;
   line_t                 buf_line;

   // byte-within-word bits never matter for a line fill
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^addr_q[1:0];

   // next-state, counter and address latch; outputs are derived from the next state
   // so they leave the flops already aligned with the state they describe
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      buf_clr = 1'b0;
      buf_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            buf_clr = 1'b1;
            if (miss_req) begin
               addr_d  = miss_addr;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // beats arriving alongside the grant belong to nobody and are dropped
            if (sys.sys_gnt) begin
               cnt_d   = '0;
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (sys.sys_valid) begin
               buf_we = 1'b1;
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      sys_req_d = (state_d == ST_REQ);
      sys_rw_d  = (state_d == ST_REQ) ? `PREAD : 1'b0;
      busy_d    = (state_d != ST_IDLE);
      line_we_d = (state_d == ST_WRITE);
   end

   // FSM state, beat counter, latched miss address and registered control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         sys_req_q <= 1'b0;
         sys_rw_q  <= 1'b0;
         busy_q    <= 1'b0;
         line_we_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         sys_req_q <= sys_req_d;
         sys_rw_q  <= sys_rw_d;
         busy_q    <= busy_d;
         line_we_q <= line_we_d;
      end
   end

   line_buffer #(
      .DATAWIDTH (DATAWIDTH),
      .WORDS     (WORDS),
      .IDX_W     (WORD_SEL_W)
   ) u_line_buffer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (buf_clr),
      .we    (buf_we),
      .widx  (cnt_q),
      .wdata (sys.sys_data),
      .line  (buf_line)
   );

   // the requested word is passed straight through on the beat that carries it
   assign crit           = addr_q[3:2];
   assign cpu_word_valid = (state_q == ST_FILL) && sys.sys_valid && (cnt_q == crit);
   assign cpu_word       = cpu_word_valid ? sys.sys_data : '0;

   assign sys.sys_req  = sys_req_q;
   assign sys.sys_rw   = sys_rw_q;
   assign sys.sys_addr = {addr_q[ADDRWIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};

   assign line_data  = buf_line;
   assign line_tag   = addr_q[ADDRWIDTH-1 -: TAG_W];
   assign line_index = addr_q[OFFSET_W +: INDEX_W];
   assign line_we    = line_we_q;
   assign fill_done  = line_we_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_line_refill.sv
// tb/tb_line_refill.sv - scoreboard bench for line_refill
`ifndef PREAD
`include "macro.sv"
`endif

module tb_line_refill;

   typedef struct {
      logic [127:0] data;
      logic [21:0]  tag;
      logic [5:0]   index;
   } line_exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              miss_req = 1'b0;
   logic [31:0]       miss_addr = '0;
   logic [31:0]       cpu_word;
   logic              cpu_word_valid;
   logic              line_we;
   logic [3:0][31:0]  line_data;
   logic [21:0]       line_tag;
   logic [5:0]        line_index;
   logic              busy;
   logic              fill_done;

   line_refill_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) bus ();

   line_refill #(.ADDRWIDTH(32), .DATAWIDTH(32), .WORDS(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .miss_req       (miss_req),
      .miss_addr      (miss_addr),
      .sys            (bus),
      .cpu_word       (cpu_word),
      .cpu_word_valid (cpu_word_valid),
      .line_we        (line_we),
      .line_data      (line_data),
      .line_tag       (line_tag),
      .line_index     (line_index),
      .busy           (busy),
      .fill_done      (fill_done)
   );

   always #5 clk = ~clk;

   logic [31:0] cpu_q[$];
   line_exp_t   line_q[$];
   int          checks = 0;
   int          errors = 0;
   int          line_cnt = 0;
   logic [31:0] mon_cpu;
   line_exp_t   mon_line;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_fill(input logic [31:0] addr, input logic [31:0] base);
      line_exp_t e;
      cpu_q.push_back(base + {30'd0, addr[3:2]});
      e.data  = {base + 32'd3, base + 32'd2, base + 32'd1, base};
      e.tag   = addr[31:10];
      e.index = addr[9:4];
      line_q.push_back(e);
   endtask

   // monitor: pops the scoreboard whenever the DUT presents a word or a line
   always @(negedge clk) begin
      if (rst_n) begin
         if (cpu_word_valid === 1'b1) begin
            if (cpu_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cpu_word: got %0h expected none", cpu_word);
            end else begin
               mon_cpu = cpu_q.pop_front();
               chk("cpu_word", cpu_word, mon_cpu);
            end
         end
         if (line_we === 1'b1) begin
            line_cnt++;
            if (line_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_line_we: got %0h expected none", line_data);
            end else begin
               mon_line = line_q.pop_front();
               chk("line_data", line_data, mon_line.data);
               chk("line_tag", line_tag, mon_line.tag);
               chk("line_index", line_index, mon_line.index);
               chk("fill_done", fill_done, 1'b1);
            end
         end else if (fill_done !== 1'b0) begin
            checks++; errors++;
            $display("FAIL fill_done_alone: got %0b expected 0", fill_done);
         end
      end
   end

   // one complete miss; gnt arrives gnt_dly cycles after REQ is entered,
   // vpat gives sys_valid per FILL cycle (LSB first)
   task automatic run_fill(input logic [31:0] addr, input int gnt_dly,
                           input logic [15:0] vpat, input int plen,
                           input logic [31:0] base, input bit spur, input bit busy_miss);
      int beat;
      logic [31:0] exp_sa;
      exp_sa = {addr[31:4], 4'h0};
      push_fill(addr, base);
      miss_addr = addr;
      miss_req  = 1'b1;
      tick();
      miss_req = 1'b0;
      chk("sys_req_req", bus.sys_req, 1'b1);
      chk("sys_addr", bus.sys_addr, exp_sa);
      chk("sys_rw", bus.sys_rw, `PREAD);
      chk("busy_req", busy, 1'b1);
      if (busy_miss) begin
         miss_addr = 32'h0000_9990;
         miss_req  = 1'b1;
      end
      for (int i = 0; i < gnt_dly; i++) begin
         tick();
         chk("sys_req_wait", bus.sys_req, 1'b1);
         chk("sys_addr_wait", bus.sys_addr, exp_sa);
      end
      bus.sys_gnt = 1'b1;
      if (spur) begin
         bus.sys_valid = 1'b1;
         bus.sys_data  = 32'hBAD0_0000;
      end
      tick();
      bus.sys_gnt   = 1'b0;
      bus.sys_valid = 1'b0;
      chk("sys_req_fill", bus.sys_req, 1'b0);
      chk("sys_rw_fill", bus.sys_rw, 1'b0);
      beat = 0;
      for (int i = 0; i < plen; i++) begin
         bus.sys_valid = vpat[i];
         bus.sys_data  = vpat[i] ? base + beat : 32'hDEAD_BEEF;
         if (busy_miss && i == plen - 1) miss_req = 1'b0;
         #1;
         chk("cpu_valid_beat", cpu_word_valid, (vpat[i] && beat == int'(addr[3:2])));
         if (vpat[i]) beat++;
         @(posedge clk);
         #1;
      end
      bus.sys_valid = 1'b0;
      chk("line_we_timing", line_we, 1'b1);
      chk("busy_write", busy, 1'b1);
      tick();
      chk("busy_idle", busy, 1'b0);
      chk("line_we_once", line_we, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      bus.sys_gnt   = 1'b0;
      bus.sys_valid = 1'b0;
      bus.sys_data  = '0;
      #2;
      chk("rst_busy", busy, 1'b0);
      chk("rst_sys_req", bus.sys_req, 1'b0);
      chk("rst_sys_rw", bus.sys_rw, 1'b0);
      chk("rst_sys_addr", bus.sys_addr, 32'h0);
      chk("rst_line_we", line_we, 1'b0);
      chk("rst_fill_done", fill_done, 1'b0);
      chk("rst_cpu_valid", cpu_word_valid, 1'b0);
      chk("rst_cpu_word", cpu_word, 32'h0);
      chk("rst_line_data", line_data, 128'h0);
      chk("rst_line_tag", line_tag, 22'h0);
      chk("rst_line_index", line_index, 6'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // basic fill, gnt in cycle 2, critical word 2
      run_fill(32'h0000_1238, 1, 16'h000F, 4, 32'h0000_00A0, 1'b0, 1'b0);

      // gapped beats, critical word 0, all-ones tag and index
      run_fill(32'hFFFF_FFF0, 0, 16'b1100101, 7, 32'h0000_00B0, 1'b0, 1'b0);

      // spurious beat and grant in IDLE
      bus.sys_valid = 1'b1;
      bus.sys_data  = 32'hBAD1_0000;
      bus.sys_gnt   = 1'b1;
      tick();
      bus.sys_valid = 1'b0;
      bus.sys_gnt   = 1'b0;
      chk("idle_spur_busy", busy, 1'b0);
      // beat alongside gnt plus a second miss while busy
      run_fill(32'h0000_0408, 2, 16'h000F, 4, 32'h0000_0050, 1'b1, 1'b1);
      tick();
      chk("second_miss_ignored", busy, 1'b0);

      // reset after two beats of a fill
      miss_addr = 32'h0000_0340;
      miss_req  = 1'b1;
      cpu_q.push_back(32'h0000_00E0);
      tick();
      miss_req    = 1'b0;
      bus.sys_gnt = 1'b1;
      tick();
      bus.sys_gnt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.sys_valid = 1'b1;
         bus.sys_data  = 32'h0000_00E0 + i;
         tick();
      end
      bus.sys_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_sys_req", bus.sys_req, 1'b0);
      chk("mid_rst_sys_addr", bus.sys_addr, 32'h0);
      chk("mid_rst_line_data", line_data, 128'h0);
      chk("mid_rst_line_tag", line_tag, 22'h0);
      chk("mid_rst_line_index", line_index, 6'h0);
      chk("mid_rst_line_we", line_we, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", busy, 1'b0);
      run_fill(32'h0000_0344, 0, 16'h000F, 4, 32'h0000_00C0, 1'b0, 1'b0);

      // back-to-back misses with miss_req held high
      push_fill(32'h0000_0100, 32'h0000_00D0);
      push_fill(32'h0000_0210, 32'h0000_00F0);
      miss_addr = 32'h0000_0100;
      miss_req  = 1'b1;
      tick();
      chk("b2b_addr1", bus.sys_addr, 32'h0000_0100);
      bus.sys_gnt = 1'b1;
      tick();
      bus.sys_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.sys_valid = 1'b1;
         bus.sys_data  = 32'h0000_00D0 + i;
         tick();
      end
      bus.sys_valid = 1'b0;
      miss_addr = 32'h0000_0210;
      chk("b2b_we1", line_we, 1'b1);
      chk("b2b_busy_write1", busy, 1'b1);
      tick();
      chk("b2b_busy_gap", busy, 1'b0);
      tick();
      chk("b2b_busy_req2", busy, 1'b1);
      chk("b2b_sys_req2", bus.sys_req, 1'b1);
      chk("b2b_addr2", bus.sys_addr, 32'h0000_0210);
      bus.sys_gnt = 1'b1;
      tick();
      bus.sys_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.sys_valid = 1'b1;
         bus.sys_data  = 32'h0000_00F0 + i;
         tick();
      end
      bus.sys_valid = 1'b0;
      miss_req = 1'b0;
      chk("b2b_we2", line_we, 1'b1);
      tick();
      chk("b2b_busy_end", busy, 1'b0);
      tick();
      chk("b2b_busy_end2", busy, 1'b0);

      repeat (3) tick();
      chk("cpu_q_empty", cpu_q.size(), 0);
      chk("line_q_empty", line_q.size(), 0);
      chk("line_we_total", line_cnt, 6);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
